uart_tx_engine: RTL

- Transmit-side serializer sitting directly downstream of the APB register slave.
- Consumes the TDR byte and LCR frame-format fields; drives the UART TXD line.
- One-entry holding register (THR) plus a shift register, so software can queue the next byte while the current frame is on the line.
- Reports THR-empty and shifter-idle status back for LSR assembly.

---
 rtl/uart_tx_engine.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmit serializer with a one-entry holding register
// (THR) in front of the shift register, so the next byte can be queued while
// the current frame is on the line.
// Optional feature: define UART_TX_BREAK_EN to add brk_i, which forces txd_o
// low while the frame machinery keeps running underneath.
module uart_tx_engine #(
  parameter int OVERSAMPLE = 16,
  parameter int TICK_CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_tick_i,
  input  logic [7:0] tdr_i,
  input  logic       tdr_wr_i,
  input  logic [4:0] lcr_i,
  output logic       txd_o,
  output logic       thr_empty_o,
  output logic       tx_empty_o,
  output logic       tx_done_o,
  output logic       thr_ovr_o,
  input  logic       ovr_clr_i
`ifdef UART_TX_BREAK_EN
  ,
  input  logic       brk_i
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_thr;
  logic                  r_thr_full;
  logic [7:0]            r_shift;
  logic [3:0]            r_lcr;      // frame format snapshot: [1:0] len, [2] 2 stop, [3] parity en
  logic                  r_par;      // parity bit precomputed at load
  logic [TICK_CNT_W-1:0] r_tick;
  logic [2:0]            r_bitcnt;
  logic                  r_stopcnt;
  logic                  r_done;
  logic                  r_ovr;
  logic                  r_tx_empty;
  logic                  w_wrap;
  logic                  w_last_bit;
  logic                  w_load;
  logic                  w_done;
  logic                  w_fsm_txd;
  logic                  w_accept;
  logic                  w_thr_full_nxt;
  logic [7:0]            w_mask;
  logic                  w_par_calc;

  assign w_wrap     = baud_tick_i && (r_tick == TICK_CNT_W'(OVERSAMPLE - 1));
  assign w_last_bit = (r_bitcnt == (3'd4 + {1'b0, r_lcr[1:0]}));

  // Parity over the N active data bits; lcr[4]=1 selects even parity.
  assign w_mask     = 8'hFF >> (2'd3 - lcr_i[1:0]);
  assign w_par_calc = (^(r_thr & w_mask)) ^ ~lcr_i[4];

  // A write is taken whenever THR is empty or is being emptied this very cycle.
  assign w_accept       = tdr_wr_i && (!r_thr_full || w_load);
  assign w_thr_full_nxt = w_accept || (r_thr_full && !w_load);

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state, THR-load strobe, frame-done strobe and line level.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    w_fsm_txd   = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (r_thr_full) begin
          w_load      = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_fsm_txd = 1'b0;
        if (w_wrap) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_fsm_txd = r_shift[0];
        if (w_wrap && w_last_bit) w_state_nxt = r_lcr[3] ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_fsm_txd = r_par;
        if (w_wrap) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        w_fsm_txd = 1'b1;
        if (w_wrap && (!r_lcr[2] || r_stopcnt)) begin
          w_done = 1'b1;
          if (r_thr_full) begin
            w_load      = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control registers: tick/bit/stop counters, THR flag, status bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick     <= '0;
      r_bitcnt   <= '0;
      r_stopcnt  <= 1'b0;
      r_thr_full <= 1'b0;
      r_done     <= 1'b0;
      r_ovr      <= 1'b0;
      r_tx_empty <= 1'b1;
    end else begin
      if (w_state_nxt != r_state)                 r_tick <= '0;
      else if (r_state != S_IDLE && baud_tick_i)  r_tick <= r_tick + TICK_CNT_W'(1);

      if (r_state != S_DATA) r_bitcnt <= '0;
      else if (w_wrap)       r_bitcnt <= r_bitcnt + 3'd1;

      if (r_state != S_STOP) r_stopcnt <= 1'b0;
      else if (w_wrap)       r_stopcnt <= 1'b1;

      r_thr_full <= w_thr_full_nxt;
      r_done     <= w_done;
      r_tx_empty <= !w_thr_full_nxt && (w_state_nxt == S_IDLE);

      if (tdr_wr_i && r_thr_full && !w_load) r_ovr <= 1'b1;
      else if (ovr_clr_i)                    r_ovr <= 1'b0;
    end
  end

  // Data registers: THR capture, shifter load/shift and frame-format snapshot.
  always_ff @(posedge clk) begin
    if (w_accept) r_thr <= tdr_i;
    if (w_load) begin
      r_shift <= r_thr;
      r_lcr   <= lcr_i[3:0];
      r_par   <= w_par_calc;
    end else if (r_state == S_DATA && w_wrap) begin
      r_shift <= r_shift >> 1;
    end
  end

`ifdef UART_TX_BREAK_EN
  logic r_brk;

  // Registered break request; gates the line low without touching the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_brk <= 1'b0;
    else          r_brk <= brk_i;
  end

  assign txd_o = w_fsm_txd & ~r_brk;
`else
  assign txd_o = w_fsm_txd;
`endif

  assign thr_empty_o = !r_thr_full;
  assign tx_empty_o  = r_tx_empty;
  assign tx_done_o   = r_done;
  assign thr_ovr_o   = r_ovr;

endmodule
